// File: rtl/ex_wb_stage_pkg.sv
// Shared ISA encodings, flag indices, stage state enum and beat decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: op1/op2/op3 encodings, branch condition codes, SZCV bit
// indices, RUN/FLUSH/HALTED state enum and the decoded-beat struct.
package ex_wb_stage_pkg;

    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_IMM = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    localparam logic [2:0] OP2_LI   = 3'b000;
    localparam logic [2:0] OP2_ADDI = 3'b001;
    localparam logic [2:0] OP2_SUBI = 3'b010;
    localparam logic [2:0] OP2_B    = 3'b100;
    localparam logic [2:0] OP2_BCC  = 3'b111;

    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // What a committed beat does, independent of datapath values.
    typedef struct packed {
        logic       wb;        // write the register file
        logic [2:0] wb_addr;
        logic       wb_mem;    // write data comes from load data, not ALU
        logic       flag_upd;  // commit in_code to the flags register
        logic       out;       // OUT-port strobe
        logic       br_always;
        logic       br_cond;   // taken depends on cond vs committed flags
        logic       hlt;
    } dec_t;

    // ALU/shifter ops that produce flags: 0000..0101 and 1000..1011.
    function automatic logic is_alu_flag_op(input logic [3:0] op3);
        return (op3 <= 4'b0101) || ((op3 >= 4'b1000) && (op3 <= 4'b1011));
    endfunction

    function automatic dec_t decode(input logic [15:0] instr);
        dec_t d;
        d = '0;
        case (instr[15:14])
            OP1_ALU: begin
                if (is_alu_flag_op(instr[7:4])) begin
                    d.flag_upd = 1'b1;
                    d.wb       = (instr[7:4] != OP3_CMP);
                    d.wb_addr  = instr[10:8];
                end else if (instr[7:4] == OP3_OUT) begin
                    d.out = 1'b1;
                end else if (instr[7:4] == OP3_HLT) begin
                    d.hlt = 1'b1;
                end
            end
            OP1_LD: begin
                d.wb      = 1'b1;
                d.wb_addr = instr[13:11];
                d.wb_mem  = 1'b1;
            end
            OP1_IMM: begin
                case (instr[13:11])
                    OP2_LI: begin
                        d.wb      = 1'b1;
                        d.wb_addr = instr[10:8];
                    end
                    OP2_ADDI, OP2_SUBI: begin
                        d.wb       = 1'b1;
                        d.wb_addr  = instr[10:8];
                        d.flag_upd = 1'b1;
                    end
                    OP2_B:   d.br_always = 1'b1;
                    OP2_BCC: d.br_cond   = 1'b1;
                    default: ;
                endcase
            end
            default: ;  // ST has no effect in this stage
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ex_wb_stage_branch_cond_eval.sv
// Conditional-branch evaluator: taken = f(cond, SZCV flags).
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_cond (3b condition code), i_flags (SZCV), o_taken.
module branch_cond_eval
    import ex_wb_stage_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    logic w_s;
    logic w_z;
    logic w_v;
    logic w_lt;
    logic w_unused;

    assign w_s      = i_flags[FLAG_S];
    assign w_z      = i_flags[FLAG_Z];
    assign w_v      = i_flags[FLAG_V];
    assign w_lt     = w_s ^ w_v;       // signed less-than after a compare
    assign w_unused = i_flags[FLAG_C]; // no condition tests carry yet

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_BE:  o_taken = w_z;
            COND_BLT: o_taken = w_lt;
            COND_BLE: o_taken = w_z | w_lt;
            COND_BNE: o_taken = ~w_z;
            default:  o_taken = 1'b0;  // 100..111 reserved, never taken
        endcase
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: commits ALU results, flags, branches, OUT and HLT.
// Latency: one cycle; every output is a register updated at the accepting edge.
// Backpressure: none; beats arriving while flushing are dropped, while halted ignored.
// Ports: clk/rst_n (sync active-low); in_* beat from ALU; wb_* regfile write;
// br_taken/br_target redirect; flags; out_en/out_data; halted.
module ex_wb_stage
    import ex_wb_stage_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_code,
    input  logic [DATA_W-1:0] in_pc1,
    input  logic [DATA_W-1:0] in_mem_rdata,
    output logic              wb_en,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic [3:0]        flags,
    output logic              out_en,
    output logic [DATA_W-1:0] out_data,
    output logic              halted
);

    state_t            r_state;
    logic [1:0]        r_flush_cnt;
    logic              r_wb_en;
    logic [2:0]        r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_br_taken;
    logic [DATA_W-1:0] r_br_target;
    logic [3:0]        r_flags;
    logic              r_out_en;
    logic [DATA_W-1:0] r_out_data;
    logic              r_halted;

    dec_t              w_dec;
    logic              w_cond_taken;
    logic              w_take;
    logic [DATA_W-1:0] w_target;

    assign w_dec    = decode(in_instr);
    assign w_take   = w_dec.br_always | (w_dec.br_cond & w_cond_taken);
    // PC-relative offset is the sign-extended low byte; the add wraps naturally.
    assign w_target = in_pc1 + {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};

    // Conditions read the committed flags, so a flag-setting beat one edge
    // earlier is already visible without any bypass.
    branch_cond_eval u_cond (
        .i_cond  (in_instr[10:8]),
        .i_flags (r_flags),
        .o_taken (w_cond_taken)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 2'd0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= 3'd0;
            r_wb_data   <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_flags     <= 4'd0;
            r_out_en    <= 1'b0;
            r_out_data  <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_wb_en    <= 1'b0;
            r_br_taken <= 1'b0;
            r_out_en   <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (in_valid) begin
                        if (w_dec.wb) begin
                            r_wb_en   <= 1'b1;
                            r_wb_addr <= w_dec.wb_addr;
                            r_wb_data <= w_dec.wb_mem ? in_mem_rdata : in_result;
                        end
                        if (w_dec.flag_upd) begin
                            r_flags <= in_code;
                        end
                        if (w_dec.out) begin
                            r_out_en   <= 1'b1;
                            r_out_data <= in_result;
                        end
                        if (w_take) begin
                            r_br_taken  <= 1'b1;
                            r_br_target <= w_target;
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= 2'(FLUSH_SLOTS);
                        end
                        if (w_dec.hlt) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Only real beats count as squashed wrong-path slots.
                    if (in_valid) begin
                        r_flush_cnt <= r_flush_cnt - 2'd1;
                        if (r_flush_cnt == 2'd1) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_HALTED: ;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;
    assign flags     = r_flags;
    assign out_en    = r_out_en;
    assign out_data  = r_out_data;
    assign halted    = r_halted;

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;

    localparam int FS = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr, in_result, in_pc1, in_mem_rdata;
    logic [3:0]  in_code;
    logic        wb_en, br_taken, out_en, halted;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data, br_target, out_data;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    ex_wb_stage #(.DATA_W(16), .FLUSH_SLOTS(FS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_result(in_result), .in_code(in_code), .in_pc1(in_pc1),
        .in_mem_rdata(in_mem_rdata), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target),
        .flags(flags), .out_en(out_en), .out_data(out_data), .halted(halted)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic drive(input logic r, input logic v, input logic [15:0] instr,
                         input logic [15:0] res, input logic [3:0] code,
                         input logic [15:0] pc1, input logic [15:0] rd);
        rst_n = r; in_valid = v; in_instr = instr; in_result = res;
        in_code = code; in_pc1 = pc1; in_mem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic        m_wb_en, m_br, m_out, m_halt;
    logic [2:0]  m_wb_addr;
    logic [15:0] m_wb_data, m_tgt, m_out_data;
    logic [3:0]  m_flags;
    int          m_skip;   // wrong-path beats still to discard

    task automatic model(input logic r, input logic v, input logic [15:0] instr,
                         input logic [15:0] res, input logic [3:0] code,
                         input logic [15:0] pc1, input logic [15:0] rd);
        int op1, op2, op3, cnd, off;
        bit s, z, ov, take;
        m_wb_en = 0; m_br = 0; m_out = 0;
        if (!r) begin
            m_wb_addr = 0; m_wb_data = 0; m_tgt = 0; m_out_data = 0;
            m_flags = 0; m_halt = 0; m_skip = 0;
            return;
        end
        if (m_halt || !v) return;
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        op1 = int'(instr[15:14]); op2 = int'(instr[13:11]);
        op3 = int'(instr[7:4]);   cnd = int'(instr[10:8]);
        s = m_flags[3]; z = m_flags[2]; ov = m_flags[0];
        take = 0;
        if (op1 == 3) begin
            if (op3 <= 5 || (op3 >= 8 && op3 <= 11)) begin
                m_flags = code;
                if (op3 != 5) begin
                    m_wb_en = 1; m_wb_addr = instr[10:8]; m_wb_data = res;
                end
            end else if (op3 == 13) begin
                m_out = 1; m_out_data = res;
            end else if (op3 == 15) begin
                m_halt = 1;
            end
        end else if (op1 == 0) begin
            m_wb_en = 1; m_wb_addr = instr[13:11]; m_wb_data = rd;
        end else if (op1 == 2) begin
            if (op2 <= 2) begin
                m_wb_en = 1; m_wb_addr = instr[10:8]; m_wb_data = res;
                if (op2 != 0) m_flags = code;
            end else if (op2 == 4) begin
                take = 1;
            end else if (op2 == 7) begin
                case (cnd)
                    0: take = z;
                    1: take = (s != ov);
                    2: take = z || (s != ov);
                    3: take = !z;
                    default: take = 0;
                endcase
            end
        end
        if (take) begin
            off = int'(instr[7:0]);
            if (off >= 128) off -= 256;
            m_br = 1;
            m_tgt = 16'((int'(pc1) + off + 65536) % 65536);
            m_skip = FS;
        end
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d.wb_en", cyc), wb_en, m_wb_en);
        chk($sformatf("rnd%0d.br_taken", cyc), br_taken, m_br);
        chk($sformatf("rnd%0d.br_target", cyc), br_target, m_tgt);
        chk($sformatf("rnd%0d.flags", cyc), flags, m_flags);
        chk($sformatf("rnd%0d.out_en", cyc), out_en, m_out);
        chk($sformatf("rnd%0d.halted", cyc), halted, m_halt);
        if (m_wb_en) begin
            chk($sformatf("rnd%0d.wb_addr", cyc), wb_addr, m_wb_addr);
            chk($sformatf("rnd%0d.wb_data", cyc), wb_data, m_wb_data);
        end
        if (m_out) chk($sformatf("rnd%0d.out_data", cyc), out_data, m_out_data);
    endtask

    function automatic logic [15:0] gen_instr();
        logic [15:0] x;
        int k, a;
        x = 16'($urandom);
        k = $urandom_range(0, 99);
        a = $urandom_range(0, 9);
        if (k < 30)      begin x[15:14] = 2'b11; x[7:4] = 4'((a < 6) ? a : a + 2); end
        else if (k < 38) begin x[15:14] = 2'b11; x[7:4] = 4'hD; end
        else if (k < 40) begin x[15:14] = 2'b11; x[7:4] = 4'hF; end
        else if (k < 52) x[15:14] = 2'b00;
        else if (k < 57) x[15:14] = 2'b01;
        else if (k < 67) begin x[15:14] = 2'b10; x[13:11] = 3'($urandom_range(0, 2)); end
        else if (k < 74) begin x[15:14] = 2'b10; x[13:11] = 3'b100; end
        else if (k < 92) begin x[15:14] = 2'b10; x[13:11] = 3'b111; end
        return x;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        v;
        logic [15:0] instr, res;
        logic [3:0]  code;
        logic [15:0] pc1, rd;
        logic        e_wb;
        logic [2:0]  e_addr;
        logic [15:0] e_data;
        logic        e_br;
        logic [15:0] e_tgt;
        logic [3:0]  e_flags;
        logic        e_out;
        logic [15:0] e_odata;
        logic        e_halt;
    } vec_t;

    vec_t tbl[19];

    initial begin
        //            v  instr     res       code     pc1       rd        wb addr data     br tgt       flags    out odata     h
        tbl[0]  = '{1, 16'hC100, 16'h0005, 4'b0000, 16'h0000, 16'h0000, 1, 1, 16'h0005, 0, 16'h0000, 4'b0000, 0, 16'h0000, 0}; // ADD R1
        tbl[1]  = '{1, 16'hC050, 16'h1234, 4'b0100, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 4'b0100, 0, 16'h0000, 0}; // CMP Z
        tbl[2]  = '{1, 16'hB803, 16'h0000, 4'b0000, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1, 16'h0013, 4'b0100, 0, 16'h0000, 0}; // BE taken
        tbl[3]  = '{1, 16'hC200, 16'h0007, 4'b0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0013, 4'b0100, 0, 16'h0000, 0}; // squashed
        tbl[4]  = '{1, 16'hC200, 16'h0008, 4'b0001, 16'h0000, 16'h0000, 1, 2, 16'h0008, 0, 16'h0013, 4'b0001, 0, 16'h0000, 0}; // commits
        tbl[5]  = '{1, 16'hC300, 16'h8000, 4'b1000, 16'h0000, 16'h0000, 1, 3, 16'h8000, 0, 16'h0013, 4'b1000, 0, 16'h0000, 0}; // S=1 V=0
        tbl[6]  = '{1, 16'hB9FE, 16'h0000, 4'b0000, 16'h0001, 16'h0000, 0, 0, 16'h0000, 1, 16'hFFFF, 4'b1000, 0, 16'h0000, 0}; // BLT wraps
        tbl[7]  = '{0, 16'hC100, 16'h0011, 4'b1001, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b1000, 0, 16'h0000, 0}; // idle in flush
        tbl[8]  = '{1, 16'hC100, 16'h0011, 4'b1001, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b1000, 0, 16'h0000, 0}; // squashed
        tbl[9]  = '{1, 16'hC100, 16'h0011, 4'b1001, 16'h0000, 16'h0000, 1, 1, 16'h0011, 0, 16'hFFFF, 4'b1001, 0, 16'h0000, 0}; // S=1 V=1
        tbl[10] = '{1, 16'hB9FE, 16'h0000, 4'b0000, 16'h0001, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b1001, 0, 16'h0000, 0}; // BLT not taken
        tbl[11] = '{1, 16'hC400, 16'h0022, 4'b0000, 16'h0000, 16'h0000, 1, 4, 16'h0022, 0, 16'hFFFF, 4'b0000, 0, 16'h0000, 0}; // commits
        tbl[12] = '{1, 16'h1A04, 16'h0000, 4'b1111, 16'h0000, 16'hBEEF, 1, 3, 16'hBEEF, 0, 16'hFFFF, 4'b0000, 0, 16'h0000, 0}; // LD R3
        tbl[13] = '{1, 16'h8500, 16'h0042, 4'b1111, 16'h0000, 16'h0000, 1, 5, 16'h0042, 0, 16'hFFFF, 4'b0000, 0, 16'h0000, 0}; // LI R5
        tbl[14] = '{1, 16'h4000, 16'h1111, 4'b1111, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b0000, 0, 16'h0000, 0}; // ST
        tbl[15] = '{1, 16'hC0D0, 16'h00AA, 4'b1111, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b0000, 1, 16'h00AA, 0}; // OUT
        tbl[16] = '{1, 16'hC0F0, 16'h0000, 4'b1111, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b0000, 0, 16'h0000, 1}; // HLT
        tbl[17] = '{1, 16'hC100, 16'h0005, 4'b1111, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b0000, 0, 16'h0000, 1}; // ignored
        tbl[18] = '{1, 16'hC100, 16'h0006, 4'b1111, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b0000, 0, 16'h0000, 1}; // ignored

        // Reset state
        drive(0, 1, 16'hC100, 16'h1234, 4'hF, 16'h0, 16'h0);
        drive(0, 0, 16'h0, 16'h0, 4'h0, 16'h0, 16'h0);
        chk("reset.wb_en", wb_en, 0);
        chk("reset.br_taken", br_taken, 0);
        chk("reset.out_en", out_en, 0);
        chk("reset.halted", halted, 0);
        chk("reset.flags", flags, 0);
        chk("reset.wb_data", wb_data, 0);
        chk("reset.br_target", br_target, 0);

        // Table-driven directed sequence
        for (int i = 0; i < 19; i++) begin
            drive(1, tbl[i].v, tbl[i].instr, tbl[i].res, tbl[i].code, tbl[i].pc1, tbl[i].rd);
            chk($sformatf("tbl%0d.wb_en", i), wb_en, tbl[i].e_wb);
            chk($sformatf("tbl%0d.br_taken", i), br_taken, tbl[i].e_br);
            chk($sformatf("tbl%0d.br_target", i), br_target, tbl[i].e_tgt);
            chk($sformatf("tbl%0d.flags", i), flags, tbl[i].e_flags);
            chk($sformatf("tbl%0d.out_en", i), out_en, tbl[i].e_out);
            chk($sformatf("tbl%0d.halted", i), halted, tbl[i].e_halt);
            if (tbl[i].e_wb) begin
                chk($sformatf("tbl%0d.wb_addr", i), wb_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d.wb_data", i), wb_data, tbl[i].e_data);
            end
            if (tbl[i].e_out) chk($sformatf("tbl%0d.out_data", i), out_data, tbl[i].e_odata);
        end

        // Reset out of HALTED: next ADD commits
        drive(0, 1, 16'hC100, 16'h0001, 4'h1, 16'h0, 16'h0);
        chk("hlt_rst.halted", halted, 0);
        chk("hlt_rst.flags", flags, 0);
        drive(1, 1, 16'hC600, 16'h0066, 4'b0010, 16'h0, 16'h0);
        chk("hlt_rst.wb_en", wb_en, 1);
        chk("hlt_rst.wb_addr", wb_addr, 6);
        chk("hlt_rst.wb_data", wb_data, 16'h0066);

        // Reset while in FLUSH
        drive(1, 1, 16'hC100, 16'h0003, 4'b0100, 16'h0, 16'h0);
        drive(1, 1, 16'hA005, 16'h0000, 4'b0000, 16'h0020, 16'h0);
        chk("flush_rst.br_taken", br_taken, 1);
        chk("flush_rst.br_target", br_target, 16'h0025);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 16'hC0D0, 16'h0077, 4'hF, 16'h0, 16'h0);
            chk($sformatf("flush_rst%0d.wb_en", i), wb_en, 0);
            chk($sformatf("flush_rst%0d.br_taken", i), br_taken, 0);
            chk($sformatf("flush_rst%0d.br_target", i), br_target, 0);
            chk($sformatf("flush_rst%0d.flags", i), flags, 0);
            chk($sformatf("flush_rst%0d.out_en", i), out_en, 0);
            chk($sformatf("flush_rst%0d.out_data", i), out_data, 0);
            chk($sformatf("flush_rst%0d.wb_data", i), wb_data, 0);
            chk($sformatf("flush_rst%0d.halted", i), halted, 0);
        end
        drive(1, 1, 16'hC500, 16'h0099, 4'b0010, 16'h0, 16'h0);
        chk("flush_rst.add_wb_en", wb_en, 1);
        chk("flush_rst.add_wb_addr", wb_addr, 5);
        chk("flush_rst.add_wb_data", wb_data, 16'h0099);
        chk("flush_rst.add_flags", flags, 4'b0010);

        // Randomised traffic against the reference model
        model(0, 0, 16'h0, 16'h0, 4'h0, 16'h0, 16'h0);
        drive(0, 0, 16'h0, 16'h0, 4'h0, 16'h0, 16'h0);
        for (int c = 0; c < 4000; c++) begin
            logic        r, v;
            logic [15:0] ins, res, pc1, rd;
            logic [3:0]  code;
            r    = ($urandom_range(0, 149) != 0);
            v    = ($urandom_range(0, 3) != 0);
            ins  = gen_instr();
            res  = 16'($urandom);
            code = 4'($urandom);
            pc1  = 16'($urandom);
            rd   = 16'($urandom);
            model(r, v, ins, res, code, pc1, rd);
            drive(r, v, ins, res, code, pc1, rd);
            check_model(c);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
